// File: rtl/shift_out_ser.sv
// Parallel-to-serial shifter with per-word length and bit order.
// Define SHIFT_OUT_SER_DBUF_EN to add a one-entry holding register for gapless back-to-back words.
module shift_out_ser #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_START,
  input  logic [DATA_WIDTH-1:0] i_D,
  input  logic [CNT_WIDTH-1:0]  i_LEN,
  input  logic                  i_LSB_FIRST,
  output logic                  o_READY,
  output logic                  o_BUSY,
  output logic                  o_Q,
  output logic                  o_VALID,
  output logic                  o_DONE
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  localparam logic [CNT_WIDTH-1:0] LEN_MAX = CNT_WIDTH'(DATA_WIDTH);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    lsb_q, lsb_d;

  logic [CNT_WIDTH-1:0]    in_len;
  logic                    accept, last;
  logic                    ld_en;
  logic [DATA_WIDTH-1:0]   ld_word;
  logic [CNT_WIDTH-1:0]    ld_len;
  logic                    ld_lsb;

  // MSB-first words are left-justified so bit N-1 always leaves from the top.
  function automatic logic [DATA_WIDTH-1:0] align(input logic [DATA_WIDTH-1:0] word,
                                                  input logic [CNT_WIDTH-1:0]  len,
                                                  input logic                  lsb);
    return lsb ? word : (word << (LEN_MAX - len));
  endfunction

  assign in_len = ((i_LEN == '0) || (i_LEN > LEN_MAX)) ? LEN_MAX : i_LEN;
  assign accept = i_START && o_READY;
  assign last   = (state_q == S_SHIFT) && (cnt_q == CNT_WIDTH'(1));

`ifdef SHIFT_OUT_SER_DBUF_EN
  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_word_q, hold_word_d;
  logic [CNT_WIDTH-1:0]  hold_len_q, hold_len_d;
  logic                  hold_lsb_q, hold_lsb_d;

  assign o_READY = !hold_vld_q;

  always_comb begin
    ld_en       = 1'b0;
    ld_word     = i_D;
    ld_len      = in_len;
    ld_lsb      = i_LSB_FIRST;
    hold_vld_d  = hold_vld_q;
    hold_word_d = hold_word_q;
    hold_len_d  = hold_len_q;
    hold_lsb_d  = hold_lsb_q;
    if (state_q == S_IDLE) begin
      ld_en = accept;
    end else if (last && hold_vld_q) begin
      ld_en      = 1'b1;
      ld_word    = hold_word_q;
      ld_len     = hold_len_q;
      ld_lsb     = hold_lsb_q;
      hold_vld_d = 1'b0;
    end else if (last) begin
      // Word arriving on the final bit bypasses the buffer to keep the stream gapless.
      ld_en = accept;
    end else if (accept) begin
      hold_vld_d  = 1'b1;
      hold_word_d = i_D;
      hold_len_d  = in_len;
      hold_lsb_d  = i_LSB_FIRST;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      hold_vld_q  <= 1'b0;
      hold_word_q <= '0;
      hold_len_q  <= '0;
      hold_lsb_q  <= 1'b0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_word_q <= hold_word_d;
      hold_len_q  <= hold_len_d;
      hold_lsb_q  <= hold_lsb_d;
    end
  end
`else
  assign o_READY = (state_q == S_IDLE);

  always_comb begin
    ld_en   = accept;
    ld_word = i_D;
    ld_len  = in_len;
    ld_lsb  = i_LSB_FIRST;
  end
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    lsb_d   = lsb_q;
    if (state_q == S_SHIFT) begin
      shreg_d = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
      cnt_d   = cnt_q - CNT_WIDTH'(1);
      if (last) state_d = S_IDLE;
    end
    if (ld_en) begin
      state_d = S_SHIFT;
      shreg_d = align(ld_word, ld_len, ld_lsb);
      cnt_d   = ld_len;
      lsb_d   = ld_lsb;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
    end
  end

  assign o_BUSY  = (state_q == S_SHIFT);
  assign o_VALID = (state_q == S_SHIFT);
  assign o_Q     = (state_q == S_SHIFT) && (lsb_q ? shreg_q[0] : shreg_q[DATA_WIDTH-1]);
  assign o_DONE  = last;

endmodule

// File: tb/tb_shift_out_ser.sv
// Scoreboard bench for shift_out_ser: driver queues expected bits, negedge monitor checks them.
module tb_shift_out_ser;
  localparam int DW = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst, start, lsb;
  logic [DW-1:0] d;
  logic [CW-1:0] len;
  logic          rdy, busy, q, vld, done;

  typedef struct packed { logic q; logic done; } exp_t;
  exp_t exp_q[$];
  int   wl[$];          // remaining bits of each word the model holds, front = word on the wire
  int   n_cmp = 0, n_err = 0;
  bit   mon_en = 0;

  shift_out_ser #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_D(d), .i_LEN(len),
    .i_LSB_FIRST(lsb), .o_READY(rdy), .o_BUSY(busy), .o_Q(q), .o_VALID(vld), .o_DONE(done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit model_ready();
`ifdef SHIFT_OUT_SER_DBUF_EN
    return wl.size() <= 1;
`else
    return wl.size() == 0;
`endif
  endfunction

  // One clock cycle: present inputs, check handshake outputs, advance the model at the edge.
  task automatic step(input logic s, input logic [DW-1:0] dd, input logic [CW-1:0] ll,
                      input logic lf, input logic r);
    int  n;
    bit  acc;
    start = s; d = dd; len = ll; lsb = lf; rst = r;
    if (mon_en) begin
      chk("ready", {31'b0, rdy}, {31'b0, model_ready()});
      chk("busy",  {31'b0, busy}, {31'b0, wl.size() > 0});
    end
    acc = s && model_ready() && !r;
    @(posedge clk);
    if (r) begin
      wl.delete();
      exp_q.delete();
    end else begin
      if (wl.size() > 0) begin
        wl[0]--;
        if (wl[0] == 0) void'(wl.pop_front());
      end
      if (acc) begin
        n = (ll == 0 || ll > DW) ? DW : int'(ll);
        wl.push_back(n);
        for (int k = 0; k < n; k++)
          exp_q.push_back('{q: dd[lf ? k : n-1-k], done: (k == n-1)});
      end
    end
    #1;
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) step(0, $urandom, CW'($urandom), 1'($urandom), 0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((wl.size() > 0 || exp_q.size() > 0) && guard < 200) begin
      idle(1);
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", 32'd1, 32'd0);
    idle(1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid", {31'b0, vld}, 32'd1);
        chk("q",     {31'b0, q},   {31'b0, e.q});
        chk("done",  {31'b0, done}, {31'b0, e.done});
      end else begin
        chk("idle_valid", {31'b0, vld}, 32'd0);
        chk("idle_q",     {31'b0, q},   32'd0);
        chk("idle_done",  {31'b0, done}, 32'd0);
      end
    end
  end

  initial begin
    start = 0; d = '0; len = '0; lsb = 0; rst = 1;
    step(1, 32'hDEADBEEF, 0, 0, 1);
    step(1, 32'hDEADBEEF, 0, 0, 1);
    mon_en = 1;
    idle(2);

    // full word, len 0 means 32, MSB first
    step(1, 32'h12345678, 0, 0, 0);
    drain();
    // full word LSB first
    step(1, 32'hF0F0F0F0, 32, 1, 0);
    drain();
    // short word: only low 8 bits leave
    step(1, 32'hFFFFFFA5, 8, 0, 0);
    drain();
    // single bit, and oversize length clamps to 32
    step(1, 32'h00000001, 1, 0, 0);
    drain();
    step(1, 32'h80000001, 40, 1, 0);
    drain();

    // reset mid-word aborts it, then a fresh word
    step(1, 32'hFFFFFFFF, 0, 0, 0);
    idle(10);
    step(0, 0, 0, 0, 1);
    idle(2);
    step(1, 32'hA5A5A5A5, 16, 1, 0);
    drain();
    // reset dominates start
    step(1, 32'hFFFFFFFF, 0, 0, 1);
    idle(3);

    // start mid-word: ignored without buffer, chained with buffer
    step(1, 32'h12345678, 0, 0, 0);
    idle(5);
    step(1, 32'h00000000, 0, 0, 0);
    drain();
    step(1, 32'h12345678, 0, 0, 0);
    idle(3);
    step(1, 32'hF0F0F0F0, 0, 1, 0);
    drain();

    // random traffic with inputs churning during shifts and occasional resets
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 2) == 0), $urandom, CW'($urandom), 1'($urandom),
           1'($urandom_range(0, 80) == 0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_out_ser.md
SHIFT_OUT_SER -- requirements
Module: shift_out_ser

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of the parallel word; SHALL be >= 2.
REQ-002 Parameter CNT_WIDTH, 6, width of i_LEN and the bit counter; SHALL satisfy 2**CNT_WIDTH > DATA_WIDTH.
REQ-003 i_CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_RST  input  1  reset; synchronous, active-high.
REQ-005 i_START  input  1  load request; accepted on a rising edge where i_START=1 and o_READY=1.
REQ-006 i_D  input  DATA_WIDTH  parallel word to serialise.
REQ-007 i_LEN  input  CNT_WIDTH  bits to send: 1..DATA_WIDTH; 0 or >DATA_WIDTH SHALL mean DATA_WIDTH.
REQ-008 i_LSB_FIRST  input  1  bit order: 0 = MSB first, 1 = LSB first.
REQ-009 o_READY  output  1  block can accept a word this cycle.
REQ-010 o_BUSY  output  1  shift in progress.
REQ-011 o_Q  output  1  serial data.
REQ-012 o_VALID  output  1  o_Q carries a valid bit this cycle.
REQ-013 o_DONE  output  1  one-cycle pulse, coincident with the last valid bit of a word.

Function
REQ-014 Two states: IDLE and SHIFT.
REQ-015 IDLE: o_BUSY=0, o_VALID=0, o_Q=0, o_DONE=0.
REQ-016 On acceptance, i_D, the effective length N and i_LSB_FIRST SHALL be latched; state -> SHIFT.
REQ-017 The first bit SHALL appear on o_Q with o_VALID=1 in the cycle after the accepting edge (latency 1).
REQ-018 Only bits i_D[N-1:0] are sent; MSB-first order is bit N-1 down to 0, LSB-first order is bit 0 up to N-1.
REQ-019 Exactly N consecutive cycles SHALL have o_VALID=1, with one new bit per cycle and no gaps.
REQ-020 o_DONE=1 in the cycle of bit N; the following cycle returns to IDLE unless a buffered word exists (REQ-027).
REQ-021 i_D, i_LEN and i_LSB_FIRST changes during SHIFT SHALL NOT affect the word in flight.
REQ-022 N=1: a single valid cycle, with o_VALID=1 and o_DONE=1 in the same cycle.

Reset
REQ-023 i_RST=1 at a rising edge SHALL force IDLE: o_Q=0, o_VALID=0, o_BUSY=0, o_DONE=0, o_READY=1 from the next cycle, and clear the counter and holding buffer.
REQ-024 Reset mid-word SHALL abort the word; no further bits of it are emitted; o_DONE SHALL NOT pulse.
REQ-025 i_RST SHALL dominate i_START at the same edge.

Configuration
REQ-026 Macro SHIFT_OUT_SER_DBUF_EN undefined: o_READY = (state==IDLE); i_START during SHIFT is ignored; consecutive words are separated by at least one idle cycle.
REQ-027 Macro SHIFT_OUT_SER_DBUF_EN defined: a one-entry holding register is added; o_READY = holding register empty.
- A word accepted during SHIFT is stored in the holding register.
- That word's first bit follows the previous word's last bit in the very next cycle, with no gap.
- o_BUSY stays 1 across the boundary.

Verification
REQ-028 Case 1: i_D=32'h12345678, i_LEN=0, MSB-first.
- o_Q sequence over 32 cycles reassembles to 32'h12345678.
- o_DONE is high on cycle 32 only; o_VALID is low on cycle 33.
REQ-029 Case 2: i_D=32'hF0F0F0F0, LSB-first, i_LEN=32.
- Bits 0..3 = 0, bits 4..7 = 1, repeating; 32 valid cycles.
REQ-030 Case 3: i_D=32'hFFFFFFA5, i_LEN=8, MSB-first.
- o_Q = 1,0,1,0,0,1,0,1; o_DONE is high on bit 8; upper bits are never emitted.
REQ-031 Case 4: i_RST asserted after bit 10 of 32'hFFFFFFFF.
- Next cycle: o_Q=0, o_VALID=0, o_BUSY=0, o_READY=1; no o_DONE.
- A new start afterwards serialises correctly.
REQ-032 Case 5, without macro: i_START pulsed mid-word with 32'h00000000 -> ignored; the first word completes unchanged.
REQ-033 Case 6, with macro: 32'h12345678 then 32'hF0F0F0F0 accepted during the first word.
- 64 consecutive valid cycles reassemble both words in order.
- o_DONE pulses on cycles 32 and 64.
